demux_scan_ctrl: RTL and testbench
==================================

Name: demux_scan_ctrl

Overview:
Upstream driver for the team's 1-to-4 demux. It takes a 4-bit per-channel data pattern and a dwell count, then steps the demux select through channels 0..3. Each channel's enable and data are held for the programmed number of cycles, and the block signals completion. Its `d`, `En` and `s` outputs connect directly to the demux's `d`, `En` and `s` inputs.

Parameters:
- NCH, 4, number of demux channels; fixed at 4 to match the 1:4 demux.
- SEL_W, 2, select width; equals log2(NCH).
- DWELL_W, 4, width of the dwell-count input.

Ports:
- clk, input, 1, single clock; all logic on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, scan request; sampled on the rising edge.
- pattern, input, NCH, data bit per channel; bit i is driven on `d` while channel i is selected.
- dwell, input, DWELL_W, cycles per channel; the value 0 is treated as 1.
- busy, output, 1, high while a scan is in progress.
- done, output, 1, one-cycle pulse after the last channel completes.
- d, output, 1, demux data input.
- En, output, 1, demux enable.
- s, output, SEL_W, demux select.

Behaviour:
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset (rst_n low, asynchronous): state goes to IDLE. busy, done, d and En are 0; s is 0; internal channel and dwell counters are 0.
- States: IDLE, SCAN, DONE.
- IDLE:
  - En=0, d=0, busy=0, done=0. s holds its last value (0 after reset).
  - On start=1 at an edge: latch pattern and dwell (0 maps to 1), set ch=0, go to SCAN.
- SCAN:
  - From the cycle after the accepting edge: En=1, s=ch, d=pattern_latched[ch], busy=1.
  - The dwell counter counts 1..dwell_latched.
  - At terminal count with ch<3: ch increments and the counter reloads; the next cycle shows the new s and d.
  - At terminal count with ch=3: go to DONE.
- DONE:
  - One cycle: En=0, d=0, busy=0, done=1.
  - Next state is IDLE, unless start=1 in this cycle, in which case a new scan is accepted exactly as from IDLE.
- Latency: from the start-accepting edge, En is high for exactly 4*dwell consecutive cycles (dwell coerced ≥1). done is high on cycle 4*dwell+1.
- start while busy=1: ignored. pattern and dwell changes during a scan are ignored (latched values are used).
- Counter width is DWELL_W. The maximum dwell of 2^DWELL_W-1 must not wrap early.
- Reset mid-scan: outputs drop asynchronously to reset values and no done pulse is produced. After rst_n rises, the block waits in IDLE for a new start.

Optional Feature:
- Macro: SCAN_BLANK_EN.
- Defined: break-before-make operation. Between consecutive channels, one blank cycle is inserted with En=0 and d=0, while s already shows the next channel. The scan then takes 4*dwell+3 cycles before done, and busy stays 1 during blank cycles.
- Undefined: no blank cycles; the timing above holds exactly.

Decomposition:
- Package demux_scan_pkg holds:
  - localparams NCH=4 and SEL_W=2;
  - state enum typedef {IDLE, SCAN, DONE}, plus BLANK when SCAN_BLANK_EN is defined;
  - the dwell-count typedef.
- One natural sub-module, demux_dwell_cnt: a loadable down-counter with a terminal-count flag, instantiated once.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release → busy=0, done=0, En=0, d=0, s=0. Assert rst_n=0 between edges → outputs clear immediately, without waiting for a clock edge.
- Basic scan: pattern=4'b1010, dwell=2, start pulse → En=1 for 8 cycles; s=0,0,1,1,2,2,3,3; d=0,0,1,1,0,0,1,1; done=1 on cycle 9; busy=0 in that cycle.
- Dwell zero: pattern=4'b1111, dwell=0 → one cycle per channel; s=0,1,2,3; done on cycle 5.
- Ignore during busy: start scan with pattern=4'b0001, dwell=3. Pulse start and change pattern to 4'b1110 on cycle 4 → sequence unchanged; exactly one done pulse at cycle 13.
- Back-to-back: assert start in the done cycle → new scan begins the next cycle with En=1, s=0 and no IDLE gap.
- Reset mid-scan: pulse rst_n low while s=2 → En=0 immediately, no done pulse, IDLE after release. With SCAN_BLANK_EN defined, pattern=4'b1111, dwell=1 → En=1,0,1,0,1,0,1 and done on cycle 8.

Source files
------------

// File: rtl/demux_scan_ctrl_pkg.sv
// Shared types and constants for the 1:4 demux scan controller.
// The SCAN_BLANK_EN build adds a BLANK state for break-before-make channel changes.
package demux_scan_pkg;

  localparam int NCH     = 4;
  localparam int SEL_W   = 2;
  localparam int DWELL_W = 4;

  typedef logic [DWELL_W-1:0] dwell_t;
  typedef logic [SEL_W-1:0]   sel_t;

  localparam dwell_t DWELL_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};
  localparam sel_t   SEL_ONE   = {{(SEL_W-1){1'b0}}, 1'b1};
  localparam sel_t   LAST_CH   = {SEL_W{1'b1}};

`ifdef SCAN_BLANK_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2, BLANK = 2'd3} state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_e;
`endif

  // A programmed dwell of zero still gives each channel one cycle.
  function automatic dwell_t dwell_coerce(input dwell_t v);
    return (v == '0) ? DWELL_ONE : v;
  endfunction

endpackage

// File: rtl/demux_scan_ctrl_dwell_cnt.sv
// Loadable dwell down-counter; tc_o flags the last cycle of a channel's dwell.
module demux_dwell_cnt
  import demux_scan_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load_i,
  input  logic   dec_i,
  input  dwell_t load_val_i,
  output logic   tc_o
);

  dwell_t cnt_q;

  // Load has priority; the count parks at zero rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - DWELL_ONE;
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign tc_o = (cnt_q == DWELL_ONE);

endmodule

// File: rtl/demux_scan_ctrl.sv
// Steps a 1:4 demux select through channels 0..3, holding En/d for a dwell per channel.
// Optional macro SCAN_BLANK_EN inserts one blank (En=0) cycle between channels.
module demux_scan_ctrl
  import demux_scan_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NCH-1:0]   pattern,
  input  logic [DWELL_W-1:0] dwell,
  output logic             busy,
  output logic             done,
  output logic             d,
  output logic             En,
  output logic [SEL_W-1:0] s
);

  state_e         state_q;
  sel_t           ch_q;
  logic [NCH-1:0] pat_q;
  dwell_t         dwell_q;
  logic           busy_q;
  logic           done_q;
  logic           d_q;
  logic           en_q;
  sel_t           s_q;

  logic   cnt_load_s;
  logic   cnt_dec_s;
  dwell_t cnt_val_s;
  logic   cnt_tc_s;
  sel_t   ch_next_s;

  assign ch_next_s = ch_q + SEL_ONE;

  // Counter control: reload on accept and at each channel boundary, else count down.
  always_comb begin
    cnt_load_s = 1'b0;
    cnt_dec_s  = 1'b0;
    cnt_val_s  = dwell_q;
    case (state_q)
      IDLE, DONE: begin
        cnt_load_s = start;
        cnt_val_s  = dwell_coerce(dwell);
      end
      SCAN: begin
        if (cnt_tc_s) begin
          cnt_load_s = 1'b1;
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
      default: begin
        cnt_load_s = 1'b0;
      end
    endcase
  end

  demux_dwell_cnt u_dwell_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load_s),
    .dec_i      (cnt_dec_s),
    .load_val_i (cnt_val_s),
    .tc_o       (cnt_tc_s)
  );

  // Scan FSM with all demux-facing outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ch_q    <= '0;
      pat_q   <= '0;
      dwell_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      d_q     <= 1'b0;
      en_q    <= 1'b0;
      s_q     <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            pat_q   <= pattern;
            dwell_q <= dwell_coerce(dwell);
            ch_q    <= '0;
            s_q     <= '0;
            en_q    <= 1'b1;
            d_q     <= pattern[0];
            busy_q  <= 1'b1;
            state_q <= SCAN;
          end else begin
            en_q    <= 1'b0;
            d_q     <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        SCAN: begin
          if (cnt_tc_s) begin
            if (ch_q == LAST_CH) begin
              en_q    <= 1'b0;
              d_q     <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              ch_q <= ch_next_s;
              s_q  <= ch_next_s;
`ifdef SCAN_BLANK_EN
              en_q    <= 1'b0;
              d_q     <= 1'b0;
              state_q <= BLANK;
`else
              d_q     <= pat_q[ch_next_s];
`endif
            end
          end
        end
`ifdef SCAN_BLANK_EN
        BLANK: begin
          en_q    <= 1'b1;
          d_q     <= pat_q[ch_q];
          state_q <= SCAN;
        end
`endif
        default: begin
          en_q    <= 1'b0;
          d_q     <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign d    = d_q;
  assign En   = en_q;
  assign s    = s_q;

endmodule

// File: tb/tb_demux_scan_ctrl.sv
// Table-driven bench for demux_scan_ctrl plus hand-written async-reset sequence.
module tb_demux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [3:0] pattern = 4'd0;
  logic [3:0] dwell = 4'd0;
  logic       busy, done, d, En;
  logic [1:0] s;
  logic [5:0] obs;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       st;
    logic [3:0] pat;
    logic [3:0] dw;
    logic [5:0] exp;   // {busy, done, En, d, s[1:0]}
  } vec_t;

  vec_t tbl[$];

  demux_scan_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .pattern (pattern),
    .dwell   (dwell),
    .busy    (busy),
    .done    (done),
    .d       (d),
    .En      (En),
    .s       (s)
  );

  always #5 clk = ~clk;

  assign obs = {busy, done, En, d, s};

  function automatic void add(input logic st, input logic [3:0] p, input logic [3:0] dw,
                              input logic [5:0] e);
    vec_t v;
    v.st = st; v.pat = p; v.dw = dw; v.exp = e;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got {busy,done,En,d,s}=%b expected=%b", name, act, exp);
    end
  endtask

  initial begin
    logic [5:0] acc;
    // Reset held for three cycles.
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1 check("reset", obs, 6'b000000);

`ifdef SCAN_BLANK_EN
    add(1'b1, 4'b1111, 4'd1, 6'b1_0_1_1_00);
    add(1'b0, 4'b1111, 4'd1, 6'b1_0_0_0_01);
    add(1'b0, 4'b1111, 4'd1, 6'b1_0_1_1_01);
    add(1'b0, 4'b1111, 4'd1, 6'b1_0_0_0_10);
    add(1'b0, 4'b1111, 4'd1, 6'b1_0_1_1_10);
    add(1'b0, 4'b1111, 4'd1, 6'b1_0_0_0_11);
    add(1'b0, 4'b1111, 4'd1, 6'b1_0_1_1_11);
    add(1'b0, 4'b1111, 4'd1, 6'b0_1_0_0_11);
    add(1'b0, 4'b1111, 4'd1, 6'b0_0_0_0_11);
`else
    // Basic scan: pattern 1010, dwell 2.
    add(1'b1, 4'b1010, 4'd2, 6'b1_0_1_0_00);
    add(1'b0, 4'b1010, 4'd2, 6'b1_0_1_0_00);
    add(1'b0, 4'b1010, 4'd2, 6'b1_0_1_1_01);
    add(1'b0, 4'b1010, 4'd2, 6'b1_0_1_1_01);
    add(1'b0, 4'b1010, 4'd2, 6'b1_0_1_0_10);
    add(1'b0, 4'b1010, 4'd2, 6'b1_0_1_0_10);
    add(1'b0, 4'b1010, 4'd2, 6'b1_0_1_1_11);
    add(1'b0, 4'b1010, 4'd2, 6'b1_0_1_1_11);
    add(1'b0, 4'b1010, 4'd2, 6'b0_1_0_0_11);
    add(1'b0, 4'b1010, 4'd2, 6'b0_0_0_0_11);
    // Dwell zero behaves as one; done cycle then starts a back-to-back scan.
    add(1'b1, 4'b1111, 4'd0, 6'b1_0_1_1_00);
    add(1'b0, 4'b1111, 4'd0, 6'b1_0_1_1_01);
    add(1'b0, 4'b1111, 4'd0, 6'b1_0_1_1_10);
    add(1'b0, 4'b1111, 4'd0, 6'b1_0_1_1_11);
    add(1'b0, 4'b1111, 4'd0, 6'b0_1_0_0_11);
    add(1'b1, 4'b0110, 4'd1, 6'b1_0_1_0_00);
    add(1'b0, 4'b0110, 4'd1, 6'b1_0_1_1_01);
    add(1'b0, 4'b0110, 4'd1, 6'b1_0_1_1_10);
    add(1'b0, 4'b0110, 4'd1, 6'b1_0_1_0_11);
    add(1'b0, 4'b0110, 4'd1, 6'b0_1_0_0_11);
    add(1'b0, 4'b0110, 4'd1, 6'b0_0_0_0_11);
    // Start and input changes during a scan are ignored.
    add(1'b1, 4'b0001, 4'd3, 6'b1_0_1_1_00);
    add(1'b0, 4'b0001, 4'd3, 6'b1_0_1_1_00);
    add(1'b0, 4'b0001, 4'd3, 6'b1_0_1_1_00);
    add(1'b1, 4'b1110, 4'd5, 6'b1_0_1_0_01);
    add(1'b0, 4'b1110, 4'd5, 6'b1_0_1_0_01);
    add(1'b0, 4'b1110, 4'd5, 6'b1_0_1_0_01);
    add(1'b0, 4'b1110, 4'd5, 6'b1_0_1_0_10);
    add(1'b0, 4'b1110, 4'd5, 6'b1_0_1_0_10);
    add(1'b0, 4'b1110, 4'd5, 6'b1_0_1_0_10);
    add(1'b0, 4'b1110, 4'd5, 6'b1_0_1_0_11);
    add(1'b0, 4'b1110, 4'd5, 6'b1_0_1_0_11);
    add(1'b0, 4'b1110, 4'd5, 6'b1_0_1_0_11);
    add(1'b0, 4'b1110, 4'd5, 6'b0_1_0_0_11);
    add(1'b0, 4'b1110, 4'd5, 6'b0_0_0_0_11);
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      start   = tbl[i].st;
      pattern = tbl[i].pat;
      dwell   = tbl[i].dw;
      @(posedge clk);
      #1 check($sformatf("vec%0d", i), obs, tbl[i].exp);
    end

    // Mid-scan async reset while channel 2 is driven.
    @(negedge clk);
    start = 1'b1; pattern = 4'b1111; dwell = 4'd2;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (s == 2'd2 && En) break;
      @(negedge clk) start = 1'b0;
    end
    start = 1'b0;
    check("pre_reset_s2", obs, 6'b1_0_1_1_10);
    #2 rst_n = 1'b0;
    #1 check("async_reset", obs, 6'b000000);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    acc = 6'b000000;
    repeat (12) begin
      @(posedge clk);
      #1 acc = acc | obs;
    end
    check("post_reset_idle", acc, 6'b000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
